uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter in the peripheral. It accepts bytes from the bus-side register interface, stores them in a circular FIFO, and feeds them one at a time to the transmitter's `start`/`tx_data` inputs. It issues the next `start` only after the transmitter's `tx_done` pulse for the previous byte.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: launch FSM encoding, default FIFO geometry and
// the baud constants used by the baud generator and transmitter.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_state_e;

  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_DATA_W = 8;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned BAUD       = 9600;
  localparam int unsigned OVERSAMPLE = 16;
  // Integer divide truncates; ~0.01% rate error at 100 MHz / 9600 x16.
  localparam int unsigned BAUD_DIV   = CLK_HZ / (BAUD * OVERSAMPLE);

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with explicit occupancy counter and sticky overflow flag.
// full/empty come from the registered count, so a push racing a pop out of a
// full FIFO is rejected.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         ovf_q, ovf_d;
  logic                         push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = wr_en && !full;
  assign pop      = rd_en && !empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set beats clear when both land in the same cycle.
    if (wr_en && full)  ovf_d = 1'b1;
    else if (ovf_clr)   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer + launch sequencer in front of the UART transmitter.
// Optional sticky "all sent" interrupt when UART_TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_done,
  output logic                     busy
`ifdef UART_TX_FIFO_IRQ_EN
  ,
  input  logic                     irq_clr,
  output logic                     irq
`endif
);

  tx_state_e         state_q, state_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (fifo_empty),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // Launch: head byte captured into tx_data and popped on the same edge.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          start_d   = 1'b1;
          tx_data_d = fifo_rd_data;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign start   = start_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q == WAIT);

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if ((state_q == WAIT) && tx_done && fifo_empty) irq_d = 1'b1;
    else if (irq_clr)                                irq_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle-accurate reference model with a byte
// scoreboard, transmitter stub pulsing tx_done a fixed latency after start.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ovf_clr = 1'b0;
  logic          tx_done = 1'b0;
  logic          full, overflow, start, busy;
  logic [CW-1:0] count;
  logic [DW-1:0] tx_data;
`ifdef UART_TX_FIFO_IRQ_EN
  logic          irq_clr = 1'b0;
  logic          irq;
  bit            m_irq;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .start    (start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy)
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    .irq_clr  (irq_clr),
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int            ncmp, nfail, cyc;
  int            tx_lat = 20;
  bit            tx_stall;
  int            tx_cnt;
  logic [DW-1:0] sb[$];
  bit            m_busy, m_ovf;
  logic [DW-1:0] m_txd;
  int            max_cnt, nstart, last_start_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: update the model for the coming edge, then compare after it.
  task automatic tick();
    int pre_n;
    bit td, exp_start;
    pre_n     = sb.size();
    td        = tx_done;
    exp_start = !reset && !m_busy && (pre_n > 0);
    if (reset) begin
      sb.delete();
      m_busy = 0; m_ovf = 0; m_txd = '0; tx_cnt = 0;
`ifdef UART_TX_FIFO_IRQ_EN
      m_irq = 0;
`endif
    end else begin
      if (wr_en && pre_n == DEPTH) m_ovf = 1;
      else if (ovf_clr)            m_ovf = 0;
      if (wr_en && pre_n < DEPTH) sb.push_back(wr_data);
`ifdef UART_TX_FIFO_IRQ_EN
      if (m_busy && td && pre_n == 0) m_irq = 1;
      else if (irq_clr)               m_irq = 0;
`endif
      if (m_busy && td) m_busy = 0;
    end
    @(posedge clk); #1; cyc++;
    chk("start", 32'(start), 32'(exp_start));
    if (exp_start) begin
      m_txd = sb.pop_front();
      m_busy = 1;
      nstart++;
      last_start_cyc = cyc;
      if (!tx_stall) tx_cnt = tx_lat;
    end
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_TX_FIFO_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
    if (sb.size() > max_cnt) max_cnt = sb.size();
    tx_done = 1'b0;
    if (!reset && tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() > 0 || m_busy) && guard < 3000) begin
      tick();
      guard++;
    end
    chk("drain_bound", 32'(guard < 3000), 32'd1);
  endtask

  initial begin
    int p_cyc, n0;
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int p_cyc, n0;
    // Reset state
    idle(3);
    reset = 1'b0;
    idle(2);

    // Single byte: start exactly one edge after the push edge
    tx_lat = 20;
    push(8'hA5);
    p_cyc = cyc;
    n0 = nstart;
    drain();
    chk("a5_nstart", 32'(nstart - n0), 32'd1);
    chk("a5_latency", 32'(last_start_cyc - p_cyc), 32'd1);
    idle(2);
    chk("a5_count0", 32'(count), 32'd0);

    // Back-to-back with the transmitter stub at 20-cycle latency
    n0 = nstart;
    push(8'h11); push(8'h22); push(8'h33);
    drain();
    chk("b2b_nstart", 32'(nstart - n0), 32'd3);
    idle(3);

    // Full / overflow with the transmitter stalled on a byte in flight
    tx_stall = 1;
    push(8'hF0);
    idle(2);
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    chk("full_before17", 32'(full), 32'd1);
    chk("ovf_before17", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    push(8'h50);                   // set beats simultaneous clear
    ovf_clr = 1'b0;
    chk("full16", 32'(count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    // Release: push lands on the pop edge from full and must be rejected
    tx_lat = 4; tx_stall = 0; tx_cnt = 1;
    tick();
    tick();
    push(8'h99);
    chk("ovf_pop_race", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    drain();
    idle(2);

    // Wrap-around: 40 bytes with interleaved drains
    tx_lat = 3; max_cnt = 0; n0 = nstart;
    for (int i = 0; i < 40; i++) begin
      push(8'(i));
      if (i % 4 == 3) idle(12);
    end
    drain();
    chk("wrap_nstart", 32'(nstart - n0), 32'd40);
    chk("wrap_max_cnt", 32'(max_cnt <= 16), 32'd1);
    chk("wrap_no_ovf", 32'(overflow), 32'd0);
    idle(2);

    // Reset mid-flight with 5 bytes buffered
    tx_lat = 50;
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    idle(3);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    idle(2);
    reset = 1'b0;
    n0 = nstart;
    idle(30);
    chk("rst_no_start", 32'(nstart - n0), 32'd0);

`ifdef UART_TX_FIFO_IRQ_EN
    // irq only after the final tx_done
    tx_lat = 10;
    push(8'h5A); push(8'h6B);
    drain();
    chk("irq_set", 32'(irq), 32'd1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    chk("irq_clr", 32'(irq), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
